// File: rtl/hangman_pkg.sv
// hangman_pkg: state encoding, character bounds and size defaults
// shared by the hangman game sequencer.
package hangman_pkg;

    localparam int CHAR_W        = 5;
    localparam int LETTER_MIN    = 1;
    localparam int LETTER_MAX    = 26;
    localparam int MAX_LEN_DEF   = 6;
    localparam int MAX_PARTS_DEF = 10;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_ENTER   = 4'd1,
        S_GUESS   = 4'd2,
        S_COMPARE = 4'd3,
        S_CHECK   = 4'd4,
        S_FILL    = 4'd5,
        S_SETTLE  = 4'd6,
        S_DRAW    = 4'd7,
        S_END     = 4'd8
    } state_e;

    function automatic logic is_letter(input int code);
        return (code >= LETTER_MIN) && (code <= LETTER_MAX);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up counter that sticks at all-ones,
// with a synchronous clear.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hangman_control.sv
// hangman_control: sequences word entry, guessing rounds and
// part drawing for two-player hangman; keeps both scores.
module hangman_control #(
    parameter int CHAR_W    = hangman_pkg::CHAR_W,
    parameter int MAX_LEN   = hangman_pkg::MAX_LEN_DEF,
    parameter int MAX_PARTS = hangman_pkg::MAX_PARTS_DEF,
    parameter int SCORE_W   = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               key_enter,
    input  logic               key_done,
    input  logic [CHAR_W-1:0]  char_in,
    input  logic               match,
    input  logic [2:0]         remain,
    input  logic               draw_finish,
    input  logic               timeout,
    output logic [CHAR_W-1:0]  char_out,
    output logic               ld_word,
    output logic               ld_guess,
    output logic               compare,
    output logic               fill,
    output logic               clear_dp,
    output logic               timer_clr,
    output logic               draw_part,
    output logic               timer_en,
    output logic [2:0]         word_len,
    output logic [3:0]         parts,
    output logic               p1_win,
    output logic               p2_win,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [3:0]         state_o
);

    import hangman_pkg::*;

    state_e              state_q, state_d;
    logic                cmp_go_q, cmp_go_d;
    logic [CHAR_W-1:0]   char_out_q, char_out_d;
    logic                ld_word_q, ld_word_d;
    logic                ld_guess_q, ld_guess_d;
    logic                compare_q, compare_d;
    logic                fill_q, fill_d;
    logic                clear_dp_q, clear_dp_d;
    logic                timer_clr_q, timer_clr_d;
    logic                draw_part_q, draw_part_d;
    logic                timer_en_q, timer_en_d;
    logic [2:0]          word_len_q, word_len_d;
    logic [3:0]          parts_q, parts_d;
    logic                p1_win_q, p1_win_d;
    logic                p2_win_q, p2_win_d;
    logic                p1_inc, p2_inc;
    logic                char_ok;
    logic                len_full;
    logic [3:0]          parts_nxt;

    assign char_ok   = is_letter(int'(char_in));
    assign len_full  = (word_len_q >= 3'(MAX_LEN));
    assign parts_nxt = parts_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        cmp_go_d    = 1'b0;
        char_out_d  = char_out_q;
        ld_word_d   = 1'b0;
        ld_guess_d  = 1'b0;
        compare_d   = 1'b0;
        clear_dp_d  = 1'b0;
        timer_clr_d = 1'b0;
        word_len_d  = word_len_q;
        parts_d     = parts_q;
        p1_win_d    = p1_win_q;
        p2_win_d    = p2_win_q;
        p1_inc      = 1'b0;
        p2_inc      = 1'b0;

        unique case (state_q)
            S_IDLE, S_END: begin
                if (start) begin
                    clear_dp_d = 1'b1;
                    word_len_d = '0;
                    parts_d    = '0;
                    p1_win_d   = 1'b0;
                    p2_win_d   = 1'b0;
                    state_d    = S_ENTER;
                end
            end
            S_ENTER: begin
                // a done arriving with an enter is dropped
                if (key_enter) begin
                    if (char_ok && !len_full) begin
                        ld_word_d  = 1'b1;
                        char_out_d = char_in;
                        word_len_d = word_len_q + 3'd1;
                    end
                end else if (key_done && (word_len_q != '0)) begin
                    timer_clr_d = 1'b1;
                    state_d     = S_GUESS;
                end
            end
            S_GUESS: begin
                if (timeout) begin
                    p1_win_d = 1'b1;
                    p1_inc   = 1'b1;
                    state_d  = S_END;
                end else if (key_enter && char_ok) begin
                    ld_guess_d = 1'b1;
                    char_out_d = char_in;
                    state_d    = S_COMPARE;
                end
            end
            S_COMPARE: begin
                // first cycle lets ld_guess land; second carries compare
                if (!cmp_go_q) begin
                    compare_d = 1'b1;
                    cmp_go_d  = 1'b1;
                end else begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = match ? S_FILL : S_DRAW;
            end
            S_FILL: begin
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (remain == '0) begin
                    p2_win_d = 1'b1;
                    p2_inc   = 1'b1;
                    state_d  = S_END;
                end else begin
                    timer_clr_d = 1'b1;
                    state_d     = S_GUESS;
                end
            end
            S_DRAW: begin
                if (draw_finish) begin
                    parts_d = parts_nxt;
                    if (parts_nxt == 4'(MAX_PARTS)) begin
                        p1_win_d = 1'b1;
                        p1_inc   = 1'b1;
                        state_d  = S_END;
                    end else begin
                        timer_clr_d = 1'b1;
                        state_d     = S_GUESS;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        fill_d      = (state_d == S_FILL);
        draw_part_d = (state_d == S_DRAW);
        timer_en_d  = (state_d == S_GUESS);
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q     <= S_IDLE;
            cmp_go_q    <= 1'b0;
            char_out_q  <= '0;
            ld_word_q   <= 1'b0;
            ld_guess_q  <= 1'b0;
            compare_q   <= 1'b0;
            fill_q      <= 1'b0;
            clear_dp_q  <= 1'b0;
            timer_clr_q <= 1'b0;
            draw_part_q <= 1'b0;
            timer_en_q  <= 1'b0;
            word_len_q  <= '0;
            parts_q     <= '0;
            p1_win_q    <= 1'b0;
            p2_win_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmp_go_q    <= cmp_go_d;
            char_out_q  <= char_out_d;
            ld_word_q   <= ld_word_d;
            ld_guess_q  <= ld_guess_d;
            compare_q   <= compare_d;
            fill_q      <= fill_d;
            clear_dp_q  <= clear_dp_d;
            timer_clr_q <= timer_clr_d;
            draw_part_q <= draw_part_d;
            timer_en_q  <= timer_en_d;
            word_len_q  <= word_len_d;
            parts_q     <= parts_d;
            p1_win_q    <= p1_win_d;
            p2_win_q    <= p2_win_d;
        end
    end

    sat_counter #(.W(SCORE_W)) u_p1_score (
        .clk (clk),
        .rst (resetn),
        .inc (p1_inc),
        .clr (1'b0),
        .cnt (p1_score)
    );

    sat_counter #(.W(SCORE_W)) u_p2_score (
        .clk (clk),
        .rst (resetn),
        .inc (p2_inc),
        .clr (1'b0),
        .cnt (p2_score)
    );

    assign state_o   = state_q;
    assign char_out  = char_out_q;
    assign ld_word   = ld_word_q;
    assign ld_guess  = ld_guess_q;
    assign compare   = compare_q;
    assign fill      = fill_q;
    assign clear_dp  = clear_dp_q;
    assign timer_clr = timer_clr_q;
    assign draw_part = draw_part_q;
    assign timer_en  = timer_en_q;
    assign word_len  = word_len_q;
    assign parts     = parts_q;
    assign p1_win    = p1_win_q;
    assign p2_win    = p2_win_q;

endmodule

// File: tb/tb_hangman_control.sv
// tb_hangman_control: directed tables, latency sequences and
// randomized games checked against a round-level game model.
module tb_hangman_control;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_ENTER  = 4'd1;
    localparam logic [3:0] ST_GUESS  = 4'd2;
    localparam logic [3:0] ST_CHECK  = 4'd4;
    localparam logic [3:0] ST_SETTLE = 4'd6;
    localparam logic [3:0] ST_DRAW   = 4'd7;
    localparam logic [3:0] ST_END    = 4'd8;

    logic       clk = 1'b0;
    logic       resetn, start, key_enter, key_done;
    logic [4:0] char_in;
    logic       match, draw_finish, timeout;
    logic [2:0] remain;
    logic [4:0] char_out;
    logic       ld_word, ld_guess, compare, fill, clear_dp, timer_clr;
    logic       draw_part, timer_en, p1_win, p2_win;
    logic [2:0] word_len;
    logic [3:0] parts, p1_score, p2_score, state_o;
    logic       outs_any;

    hangman_control dut (
        .clk(clk), .resetn(resetn), .start(start),
        .key_enter(key_enter), .key_done(key_done),
        .char_in(char_in), .match(match), .remain(remain),
        .draw_finish(draw_finish), .timeout(timeout),
        .char_out(char_out), .ld_word(ld_word),
        .ld_guess(ld_guess), .compare(compare), .fill(fill),
        .clear_dp(clear_dp), .timer_clr(timer_clr),
        .draw_part(draw_part), .timer_en(timer_en),
        .word_len(word_len), .parts(parts),
        .p1_win(p1_win), .p2_win(p2_win),
        .p1_score(p1_score), .p2_score(p2_score),
        .state_o(state_o)
    );

    assign outs_any = |{char_out, ld_word, ld_guess, compare, fill,
                        clear_dp, timer_clr, draw_part, timer_en,
                        word_len, parts, p1_win, p2_win,
                        p1_score, p2_score, state_o};

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       ke;
        logic       kd;
        logic [4:0] ch;
        logic       exp_ld;
        logic [4:0] exp_ch;
        logic [2:0] exp_len;
        logic [3:0] exp_st;
        logic       exp_tc;
    } ent_vec_t;

    ent_vec_t tv[7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic key(input logic [4:0] ch);
        key_enter = 1'b1;
        char_in   = ch;
        tick;
        key_enter = 1'b0;
    endtask

    task automatic done_key;
        key_done = 1'b1;
        tick;
        key_done = 1'b0;
    endtask

    task automatic guess(input logic m, input logic [2:0] rem,
                         input int dly);
        match  = m;
        remain = rem;
        key(5'd7);
        tick;
        tick;
        tick;
        if (!m) begin
            for (int j = 0; j <= dly; j++) begin
                if (j == dly) draw_finish = 1'b1;
                tick;
            end
            draw_finish = 1'b0;
        end else begin
            tick;
            tick;
        end
    endtask

    // round-level model state
    int m_p1w, m_p2w, m_parts, m_len, m_valid, winner, hi;

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{1'b0, 1'b1, 5'd0,  1'b0, 5'd0,  3'd0, ST_ENTER, 1'b0};
        tv[1] = '{1'b1, 1'b0, 5'd3,  1'b1, 5'd3,  3'd1, ST_ENTER, 1'b0};
        tv[2] = '{1'b1, 1'b0, 5'd0,  1'b0, 5'd3,  3'd1, ST_ENTER, 1'b0};
        tv[3] = '{1'b1, 1'b0, 5'd27, 1'b0, 5'd3,  3'd1, ST_ENTER, 1'b0};
        tv[4] = '{1'b1, 1'b0, 5'd1,  1'b1, 5'd1,  3'd2, ST_ENTER, 1'b0};
        tv[5] = '{1'b1, 1'b1, 5'd20, 1'b1, 5'd20, 3'd3, ST_ENTER, 1'b0};
        tv[6] = '{1'b0, 1'b1, 5'd20, 1'b0, 5'd20, 3'd3, ST_GUESS, 1'b1};

        resetn = 1'b1; start = 0; key_enter = 0; key_done = 0;
        char_in = '0; match = 0; remain = '0;
        draw_finish = 0; timeout = 0;
        tick;
        tick;
        chk("reset_outs", outs_any, 0);
        resetn = 1'b0;
        tick;
        chk("idle_state", state_o, ST_IDLE);

        do_start;
        chk("start_clear_dp", clear_dp, 1);
        chk("start_state", state_o, ST_ENTER);

        foreach (tv[i]) begin
            key_enter = tv[i].ke;
            key_done  = tv[i].kd;
            char_in   = tv[i].ch;
            tick;
            key_enter = 1'b0;
            key_done  = 1'b0;
            chk($sformatf("ent%0d_ld", i), ld_word, tv[i].exp_ld);
            chk($sformatf("ent%0d_ch", i), char_out, tv[i].exp_ch);
            chk($sformatf("ent%0d_len", i), word_len, tv[i].exp_len);
            chk($sformatf("ent%0d_st", i), state_o, tv[i].exp_st);
            chk($sformatf("ent%0d_tc", i), timer_clr, tv[i].exp_tc);
        end
        chk("guess_timer_en", timer_en, 1);

        // hit path latency to a p2 win
        match = 1'b1;
        remain = 3'd0;
        key(5'd5);
        chk("hit_ld_guess", ld_guess, 1);
        chk("hit_char_out", char_out, 5);
        chk("hit_cmp_early", compare, 0);
        tick;
        chk("hit_compare", compare, 1);
        chk("hit_ld_drop", ld_guess, 0);
        tick;
        chk("hit_check_st", state_o, ST_CHECK);
        chk("hit_fill_early", fill, 0);
        tick;
        chk("hit_fill", fill, 1);
        tick;
        chk("hit_settle_st", state_o, ST_SETTLE);
        tick;
        chk("hit_end_st", state_o, ST_END);
        chk("hit_p2_win", p2_win, 1);
        chk("hit_p2_score", p2_score, 1);
        chk("hit_timer_en", timer_en, 0);

        // restart, overflow entry, then ten slow misses
        do_start;
        chk("re_clear_dp", clear_dp, 1);
        chk("re_p2_win", p2_win, 0);
        chk("re_len", word_len, 0);
        chk("re_p2_keep", p2_score, 1);
        hi = 0;
        for (int i = 0; i < 7; i++) begin
            key(5'(i + 1));
            if (ld_word) hi++;
        end
        chk("ovf_strobes", hi, 6);
        chk("ovf_len", word_len, 6);
        chk("ovf_last_ch", char_out, 6);
        done_key;
        chk("ovf_guess_st", state_o, ST_GUESS);

        match = 1'b0;
        for (int i = 0; i < 10; i++) begin
            key(5'd9);
            tick;
            tick;
            tick;
            hi = 0;
            for (int j = 0; j < 16; j++) begin
                if (draw_part) hi++;
                if (j == 15) draw_finish = 1'b1;
                tick;
            end
            draw_finish = 1'b0;
            chk($sformatf("miss%0d_hi", i), hi, 16);
            chk($sformatf("miss%0d_parts", i), parts, i + 1);
            chk($sformatf("miss%0d_drop", i), draw_part, 0);
            if (i < 9) chk($sformatf("miss%0d_tc", i), timer_clr, 1);
        end
        chk("miss_end_st", state_o, ST_END);
        chk("miss_p1_win", p1_win, 1);
        chk("miss_p1_score", p1_score, 1);

        // timeout beats a simultaneous guess
        do_start;
        key(5'd1);
        done_key;
        key_enter = 1'b1;
        timeout   = 1'b1;
        char_in   = 5'd4;
        tick;
        key_enter = 1'b0;
        timeout   = 1'b0;
        chk("race_no_ld", ld_guess, 0);
        chk("race_end_st", state_o, ST_END);
        chk("race_p1_score", p1_score, 2);

        // asynchronous reset in the middle of DRAW
        do_start;
        key(5'd2);
        done_key;
        match = 1'b0;
        key(5'd9);
        tick;
        tick;
        tick;
        chk("pre_rst_draw", state_o, ST_DRAW);
        #2 resetn = 1'b1;
        #1;
        chk("rst_async_outs", outs_any, 0);
        tick;
        resetn = 1'b0;
        tick;
        chk("rst_release_outs", outs_any, 0);

        // randomized games against the round model
        m_p1w = 0;
        m_p2w = 0;
        for (int r = 0; r < 20; r++) begin
            do_start;
            chk("rnd_start_parts", parts, 0);
            m_valid = 0;
            for (int k = $urandom_range(1, 8); k > 0; k--) begin
                char_in = 5'($urandom_range(0, 31));
                if (char_in >= 1 && char_in <= 26) m_valid++;
                key(char_in);
            end
            if (m_valid == 0) begin
                key(5'd26);
                m_valid = 1;
            end
            m_len = (m_valid > 6) ? 6 : m_valid;
            done_key;
            chk("rnd_len", word_len, m_len);
            chk("rnd_guess_st", state_o, ST_GUESS);
            m_parts = 0;
            winner = 0;
            for (int g = 0; g < 60 && winner == 0; g++) begin
                if (g == 59 || $urandom_range(0, 9) == 0) begin
                    timeout = 1'b1;
                    tick;
                    timeout = 1'b0;
                    winner = 1;
                end else if ($urandom_range(0, 1) == 1) begin
                    remain = 3'($urandom_range(0, 3));
                    guess(1'b1, remain, 0);
                    if (remain == 0) winner = 2;
                end else begin
                    guess(1'b0, 3'd0, $urandom_range(0, 3));
                    m_parts++;
                    if (m_parts == 10) winner = 1;
                end
            end
            if (winner == 1) m_p1w++;
            else m_p2w++;
            chk("rnd_end_st", state_o, ST_END);
            chk("rnd_p1_win", p1_win, winner == 1);
            chk("rnd_p2_win", p2_win, winner == 2);
            chk("rnd_parts", parts, m_parts);
            chk("rnd_p1_score", p1_score, sat15(m_p1w));
            chk("rnd_p2_score", p2_score, sat15(m_p2w));
        end

        // p1 score saturation
        for (int r = 0; r < 16; r++) begin
            do_start;
            key(5'd3);
            done_key;
            timeout = 1'b1;
            tick;
            timeout = 1'b0;
            m_p1w++;
            chk("sat_p1_score", p1_score, sat15(m_p1w));
        end
        chk("sat_p1_final", p1_score, 15);
        chk("sat_p2_keep", p2_score, sat15(m_p2w));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
